pq_arbiter: RTL and testbench
=============================

// Module: pq_arbiter
// PURPOSE
//  Shares one pq_pkg priority queue among NREQ requesters (LFSR traffic sources, test FSMs).
//  Round-robin picks one eligible enqueue/dequeue request at a time and issues it to the PQ.
//  It waits out pq_busy, then returns the dequeued kv_t to the requester that owns the op.
//  Sits between the requesters and the client side of pq_if, in place of direct FSM enq/deq drive.
// PARAMETERS
//  NREQ     4   number of requesters, 2..8
//  TIMEOUT  64  max WAIT cycles with pq_busy=1 before abort, >=2
// PORTS
//  clk        in   1          system clock, all state on rising edge
//  rst        in   1          synchronous, active-high reset
//  req_enq    in   NREQ       per-requester enqueue request, level, held until gnt
//  req_deq    in   NREQ       per-requester dequeue request, level, held until gnt
//  req_kv     in   NREQ x 8   per-requester kv_t to enqueue, stable while req_enq=1
//  gnt        out  NREQ       one-hot, 1-cycle pulse: request accepted
//  rsp_valid  out  NREQ       one-hot, 1-cycle pulse: rsp_kv valid for that requester (deq only)
//  rsp_kv     out  8          kv_t returned by the dequeue, shared by all requesters
//  done       out  1          1-cycle pulse: current op (enq or deq) complete
//  err_tmo    out  1          1-cycle pulse: op aborted on timeout
//  active_id  out  $clog2(NREQ)  index of the owner of the current/last op
//  pq_enq     out  1          to pq_if.enq, 1-cycle pulse
//  pq_deq     out  1          to pq_if.deq, 1-cycle pulse
//  pq_kvi     out  8          to pq_if.kvi
//  pq_kvo     in   8          from pq_if.kvo
//  pq_full    in   1          PQ full
//  pq_empty   in   1          PQ empty
//  pq_busy    in   1          PQ busy
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0, rsp_kv 0, timeout counter 0; any op in flight is abandoned, with no gnt/rsp/done.
//  Eligibility (sampled in IDLE only): req i is eligible if (req_deq[i] & !pq_empty) | (req_enq[i] & !pq_full).
//    If both req_deq[i] and req_enq[i] are set: deq if !pq_empty, else enq if !pq_full.
//    Ineligible requests are skipped, not granted; they stay pending and are re-evaluated each IDLE cycle.
//  FSM (all outputs registered):
//    IDLE:  if !pq_busy and some req eligible: pick first eligible index from ptr upward, wrapping at NREQ.
//           Latch index, op, and req_kv. Go to ISSUE. Otherwise stay in IDLE.
//    ISSUE: exactly 1 cycle. pq_enq or pq_deq = 1, pq_kvi = latched kv (0 for deq), gnt[idx] = 1.
//           ptr <= (idx+1) mod NREQ. Go to WAIT.
//    WAIT:  at least 1 cycle. While pq_busy=1, count up. First cycle with pq_busy=0: capture pq_kvo into rsp_kv if op=deq, go to RESP.
//           If the count reaches TIMEOUT: err_tmo = 1 for 1 cycle, no rsp_valid or done, go to IDLE.
//    RESP:  1 cycle. done = 1; rsp_valid[idx] = 1 iff op=deq. Go to IDLE.
//  Latency: eligible in IDLE at cycle t -> gnt/pq_* at t+1 -> earliest done at t+3 (pq_busy never high).
//  Minimum spacing between ops is 4 cycles. At most one op is outstanding.
//  Requester rule: deassert req in the cycle after gnt. The block does not re-sample req until the next IDLE.
//    A request withdrawn before gnt is simply never granted.
//  pq_kvi holds its value outside ISSUE. rsp_kv holds until the next deq capture.
//  active_id updates in ISSUE and holds.
//  Timeout counter: $clog2(TIMEOUT+1) bits, cleared on entry to WAIT, saturates, never wraps.
//  No starvation: with every requester continuously eligible, grants go 0,1,..,NREQ-1,0,...
// STRUCTURE
//  pq_pkg gets: typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;
//    typedef enum logic {OP_ENQ, OP_DEQ} pq_op_t; localparam KV_W = $bits(kv_t).
//  One sub-module: rr_pick. Combinational: inputs elig[NREQ] and ptr; outputs idx and any.
//  The FSM, latches, and timeout counter stay in pq_arbiter.
// TESTING
//  1. Reset, then req_enq[2]=1, req_kv[2]=8'h5A, PQ idle/empty -> gnt[2] and pq_enq with pq_kvi=8'h5A at t+1; done at t+3; rsp_valid stays 0.
//  2. All four req_deq=1, PQ non-empty, busy=0 -> gnts in order 0,1,2,3,0, 4 cycles apart; each rsp_valid[i] carries pq_kvo sampled in its WAIT.
//  3. pq_full=1, req_enq[0]=1 and req_deq[1]=1 -> req 1 granted, req 0 skipped. Drop full -> req 0 granted next.
//  4. pq_busy held high 10 cycles after ISSUE -> rsp_valid/done delayed to the cycle after busy falls; busy held 64 cycles -> err_tmo pulse, IDLE, no done.
//  5. rst asserted in WAIT -> next cycle all outputs 0, ptr=0; a pending req is re-granted from index 0 after rst drops.
//  6. req_enq[3]=req_deq[3]=1 with pq_empty=1 -> enq issued; with pq_empty=0 -> deq issued.

Source files
------------

// File: rtl/pq_pkg.sv
// Purpose: shared types for the priority queue and the arbiter in front of it.
// Contents: kv_t record, arbiter FSM states, op encoding, KV_W width.
// Latency/backpressure: n/a (types only).
package pq_pkg;

  // 8-bit key/value record carried through the priority queue.
  typedef struct packed {
    logic [3:0] key;
    logic [3:0] val;
  } kv_t;

  localparam int KV_W = $bits(kv_t);

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_t;

  typedef enum logic {OP_ENQ, OP_DEQ} pq_op_t;

endpackage

// File: rtl/pq_arbiter_rr_pick.sv
// Purpose: round-robin selector: first set bit of elig at or after ptr, wrapping at NREQ.
// Latency: purely combinational.
// Backpressure: none; any=0 means nothing eligible and idx is then 0.
// Ports: elig (per-requester eligible), ptr (start index), idx (winner), any (winner exists).
module rr_pick #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] elig,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    logic [IW-1:0] jj;
    j   = 0;
    jj  = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // Walk ptr, ptr+1, ... modulo NREQ; first eligible hit wins.
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = IW'(j);
      if (!any && elig[jj]) begin
        any = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/pq_arbiter.sv
// Purpose: shares one priority queue among NREQ requesters, round-robin, one op at a time.
// Latency: eligible in IDLE at t -> gnt/pq_enq|pq_deq at t+1 -> done at t+3 if pq_busy stays low.
// Backpressure: requests wait while pq_busy or PQ full/empty makes them ineligible; WAIT aborts after TIMEOUT busy cycles.
// Ports: req_enq/req_deq/req_kv from requesters; gnt/rsp_valid/rsp_kv/done/err_tmo/active_id back to them;
//        pq_enq/pq_deq/pq_kvi drive the PQ client side; pq_kvo/pq_full/pq_empty/pq_busy come back from it.
module pq_arbiter
  import pq_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IW = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_enq,
  input  logic [NREQ-1:0]            req_deq,
  input  logic [NREQ-1:0][KV_W-1:0]  req_kv,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rsp_valid,
  output logic [KV_W-1:0]            rsp_kv,
  output logic                       done,
  output logic                       err_tmo,
  output logic [IW-1:0]              active_id,
  output logic                       pq_enq,
  output logic                       pq_deq,
  output logic [KV_W-1:0]            pq_kvi,
  input  logic [KV_W-1:0]            pq_kvo,
  input  logic                       pq_full,
  input  logic                       pq_empty,
  input  logic                       pq_busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t       state_q, state_d;
  pq_op_t           op_q, op_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    active_id_q, active_id_d;
  logic [KV_W-1:0]  pq_kvi_q, pq_kvi_d;
  logic [KV_W-1:0]  rsp_kv_q, rsp_kv_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic             done_q, done_d;
  logic             err_tmo_q, err_tmo_d;
  logic             pq_enq_q, pq_enq_d;
  logic             pq_deq_q, pq_deq_d;

  // Dequeue takes precedence when a requester asks for both and the PQ has data.
  logic [NREQ-1:0]  deq_ok;
  logic [NREQ-1:0]  elig;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  assign deq_ok = req_deq & {NREQ{~pq_empty}};
  assign elig   = deq_ok | (req_enq & {NREQ{~pq_full}});

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .elig (elig),
    .ptr  (ptr_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    active_id_d = active_id_q;
    pq_kvi_d    = pq_kvi_q;
    rsp_kv_d    = rsp_kv_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    done_d      = 1'b0;
    err_tmo_d   = 1'b0;
    pq_enq_d    = 1'b0;
    pq_deq_d    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // Outputs are registered, so the ISSUE-cycle pulses are loaded on this transition.
        if (!pq_busy && pick_any) begin
          state_d            = ARB_ISSUE;
          active_id_d        = pick_idx;
          gnt_d[pick_idx]    = 1'b1;
          if (deq_ok[pick_idx]) begin
            op_d     = OP_DEQ;
            pq_deq_d = 1'b1;
            pq_kvi_d = '0;
          end else begin
            op_d     = OP_ENQ;
            pq_enq_d = 1'b1;
            pq_kvi_d = req_kv[pick_idx];
          end
        end
      end

      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        cnt_d   = '0;
        ptr_d   = (active_id_q == IW'(NREQ - 1)) ? '0 : active_id_q + IW'(1);
      end

      ARB_WAIT: begin
        if (!pq_busy) begin
          state_d = ARB_RESP;
          done_d  = 1'b1;
          if (op_q == OP_DEQ) begin
            rsp_kv_d                 = pq_kvo;
            rsp_valid_d[active_id_q] = 1'b1;
          end
        end else begin
          if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + CW'(1);
          // This busy cycle is the TIMEOUT-th one: give up, no done/rsp.
          if (cnt_q >= CW'(TIMEOUT - 1)) begin
            err_tmo_d = 1'b1;
            state_d   = ARB_IDLE;
          end
        end
      end

      ARB_RESP: begin
        state_d = ARB_IDLE;
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      op_q        <= OP_ENQ;
      ptr_q       <= '0;
      cnt_q       <= '0;
      active_id_q <= '0;
      pq_kvi_q    <= '0;
      rsp_kv_q    <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      done_q      <= 1'b0;
      err_tmo_q   <= 1'b0;
      pq_enq_q    <= 1'b0;
      pq_deq_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      active_id_q <= active_id_d;
      pq_kvi_q    <= pq_kvi_d;
      rsp_kv_q    <= rsp_kv_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      done_q      <= done_d;
      err_tmo_q   <= err_tmo_d;
      pq_enq_q    <= pq_enq_d;
      pq_deq_q    <= pq_deq_d;
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_kv    = rsp_kv_q;
  assign done      = done_q;
  assign err_tmo   = err_tmo_q;
  assign active_id = active_id_q;
  assign pq_enq    = pq_enq_q;
  assign pq_deq    = pq_deq_q;
  assign pq_kvi    = pq_kvi_q;

endmodule

// File: tb/tb_pq_arbiter.sv
// Purpose: directed stimulus for pq_arbiter with a cycle-stamped scoreboard and a negedge monitor.
// Latency: expected events carry the absolute cycle they must appear in.
// Backpressure: pq_busy/pq_full/pq_empty are driven directly by the stimulus.
module tb_pq_arbiter;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req_enq, req_deq;
  logic [3:0][7:0] req_kv;
  logic [3:0]      gnt, rsp_valid;
  logic [7:0]      rsp_kv;
  logic            done, err_tmo;
  logic [1:0]      active_id;
  logic            pq_enq, pq_deq;
  logic [7:0]      pq_kvi, pq_kvo;
  logic            pq_full, pq_empty, pq_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [3:0] rsp_valid;
    logic [7:0] rsp_kv;
    logic       done;
    logic       err;
    logic       enq;
    logic       deq;
    logic [7:0] kvi;
    logic [1:0] aid;
  } ev_t;

  ev_t exp_q[$];

  pq_arbiter #(.NREQ(4), .TIMEOUT(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_enq   (req_enq),
    .req_deq   (req_deq),
    .req_kv    (req_kv),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_kv    (rsp_kv),
    .done      (done),
    .err_tmo   (err_tmo),
    .active_id (active_id),
    .pq_enq    (pq_enq),
    .pq_deq    (pq_deq),
    .pq_kvi    (pq_kvi),
    .pq_kvo    (pq_kvo),
    .pq_full   (pq_full),
    .pq_empty  (pq_empty),
    .pq_busy   (pq_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int c, input logic [3:0] g, input logic [3:0] rv,
                         input logic [7:0] kv, input logic dn, input logic er,
                         input logic en, input logic de, input logic [7:0] ki,
                         input logic [1:0] aid);
    ev_t e;
    e.cyc = c; e.gnt = g; e.rsp_valid = rv; e.rsp_kv = kv; e.done = dn;
    e.err = er; e.enq = en; e.deq = de; e.kvi = ki; e.aid = aid;
    exp_q.push_back(e);
  endtask

  // Request eligible in IDLE at cycle t: ISSUE at t+1, RESP at t+3.
  task automatic op_expect(input int t, input int id, input bit is_deq,
                           input logic [7:0] kvi, input logic [7:0] kvo);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    push_ev(t + 1, oh, 4'b0, 8'h00, 1'b0, 1'b0, !is_deq, is_deq,
            is_deq ? 8'h00 : kvi, 2'(id));
    push_ev(t + 3, 4'b0, is_deq ? oh : 4'b0, kvo, 1'b1, 1'b0, 1'b0, 1'b0,
            8'h00, 2'(id));
  endtask

  task automatic check_zero(input string name);
    logic [33:0] v;
    v = {gnt, rsp_valid, rsp_kv, done, err_tmo, active_id, pq_enq, pq_deq, pq_kvi};
    total++;
    if (v !== 34'h0) begin
      bad++;
      $display("FAIL %s: outputs=%h required all zero", name, v);
    end
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    req_enq = '0;
    req_deq = '0;
    pq_busy = 1'b0;
    step(2);
    check_zero(name);
    rst = 1'b0;
    step(1);
  endtask

  // Monitor: every cycle with any pulse must match the next expected event.
  always @(negedge clk) begin : mon
    ev_t e;
    bit ok;
    if (gnt != 0 || rsp_valid != 0 || done || err_tmo || pq_enq || pq_deq) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output cyc=%0d got gnt=%b rv=%b done=%b err=%b enq=%b deq=%b required no event",
                 cyc, gnt, rsp_valid, done, err_tmo, pq_enq, pq_deq);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.cyc == cyc) && (gnt == e.gnt) && (rsp_valid == e.rsp_valid) &&
             (done == e.done) && (err_tmo == e.err) && (pq_enq == e.enq) &&
             (pq_deq == e.deq) && (active_id == e.aid);
        if (e.enq || e.deq) ok = ok && (pq_kvi == e.kvi);
        if (e.rsp_valid != 0) ok = ok && (rsp_kv == e.rsp_kv);
        if (!ok) begin
          bad++;
          $display("FAIL event: got cyc=%0d gnt=%b rv=%b kv=%h done=%b err=%b enq=%b deq=%b kvi=%h aid=%0d required cyc=%0d gnt=%b rv=%b kv=%h done=%b err=%b enq=%b deq=%b kvi=%h aid=%0d",
                   cyc, gnt, rsp_valid, rsp_kv, done, err_tmo, pq_enq, pq_deq, pq_kvi, active_id,
                   e.cyc, e.gnt, e.rsp_valid, e.rsp_kv, e.done, e.err, e.enq, e.deq, e.kvi, e.aid);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b1;
    req_enq = '0; req_deq = '0; req_kv = '0;
    pq_kvo = 8'h00; pq_full = 1'b0; pq_empty = 1'b1; pq_busy = 1'b0;
    do_reset("reset_init");

    // 1: single enqueue from requester 2
    t = cyc;
    req_kv[2] = 8'h5A; req_enq[2] = 1'b1;
    op_expect(t, 2, 1'b0, 8'h5A, 8'h00);
    step(2); req_enq[2] = 1'b0;
    step(4);

    // 2: all four dequeue continuously; grants 0,1,2,3,0 four cycles apart
    do_reset("reset_t2");
    t = cyc;
    pq_empty = 1'b0;
    pq_kvo = 8'(t) ^ 8'h5A;
    req_deq = 4'hF;
    for (int k = 0; k < 5; k++)
      op_expect(t + 4 * k, k % 4, 1'b1, 8'h00, 8'(t + 4 * k + 2) ^ 8'h5A);
    for (int i = 1; i <= 19; i++) begin
      step(1);
      pq_kvo = 8'(cyc) ^ 8'h5A;
      if (i == 18) req_deq = 4'h0;
    end
    step(3);

    // 3: PQ full skips the enqueue, dequeue goes first; enqueue follows once full drops
    do_reset("reset_t3");
    t = cyc;
    pq_full = 1'b1; pq_empty = 1'b0; pq_kvo = 8'h21;
    req_kv[0] = 8'hC3; req_enq[0] = 1'b1; req_deq[1] = 1'b1;
    op_expect(t, 1, 1'b1, 8'h00, 8'h21);
    step(2); req_deq[1] = 1'b0;
    step(3); pq_full = 1'b0;
    op_expect(t + 5, 0, 1'b0, 8'hC3, 8'h00);
    step(2); req_enq[0] = 1'b0;
    step(4);

    // 4a: busy for 10 cycles after ISSUE delays the response
    t = cyc;
    pq_kvo = 8'h00; req_deq[2] = 1'b1;
    push_ev(t + 1, 4'b0100, 4'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd2);
    push_ev(t + 13, 4'b0, 4'b0100, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2);
    step(2); pq_busy = 1'b1; req_deq[2] = 1'b0;
    step(10); pq_busy = 1'b0; pq_kvo = 8'h3C;
    step(4);

    // 4b: busy for 64 cycles aborts with err_tmo and no done
    t = cyc;
    req_kv[1] = 8'h77; req_enq[1] = 1'b1;
    push_ev(t + 1, 4'b0010, 4'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 2'd1);
    push_ev(t + 66, 4'b0, 4'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1);
    step(2); pq_busy = 1'b1; req_enq[1] = 1'b0;
    step(64); pq_busy = 1'b0;
    step(4);

    // 5: reset during WAIT; afterwards the pointer restarts at 0 (req 1 before req 3)
    t = cyc;
    req_deq[1] = 1'b1;
    push_ev(t + 1, 4'b0010, 4'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1);
    step(2); pq_busy = 1'b1; req_deq[3] = 1'b1;
    step(1); rst = 1'b1;
    step(1); check_zero("reset_in_wait"); pq_busy = 1'b0; pq_kvo = 8'h4D;
    step(1); rst = 1'b0;
    op_expect(t + 5, 1, 1'b1, 8'h00, 8'h4D);
    op_expect(t + 9, 3, 1'b1, 8'h00, 8'h4D);
    step(2); req_deq[1] = 1'b0;
    step(4); req_deq[3] = 1'b0;
    step(4);

    // 6: both enq and deq from requester 3: enq when empty, deq otherwise
    t = cyc;
    pq_empty = 1'b1;
    req_kv[3] = 8'hE1; req_enq[3] = 1'b1; req_deq[3] = 1'b1;
    op_expect(t, 3, 1'b0, 8'hE1, 8'h00);
    step(2); req_enq[3] = 1'b0; req_deq[3] = 1'b0;
    step(3);
    t = cyc;
    pq_empty = 1'b0; pq_kvo = 8'h92;
    req_enq[3] = 1'b1; req_deq[3] = 1'b1;
    op_expect(t, 3, 1'b1, 8'h00, 8'h92);
    step(2); req_enq[3] = 1'b0; req_deq[3] = 1'b0;
    step(6);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_events: pending=%0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
